pattern_gen: RTL and testbench

- Parametrised multi-channel test-pattern source for exercising ADC capture, SDRAM write and GPIO-bus datapaths without live analogue input.
- Generalises the free-running reset-to-zero counter to selectable modes, start/step, per-channel offset, finite bursts and a valid/ready output stream.
- Sits between the board-level wrapper and the capture/SDRAM path. Also used as a bench stimulus source.

---
 rtl/pattern_gen_pkg.sv | 53 +++++
 rtl/pattern_lfsr.sv | 32 +++
 rtl/pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_pattern_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and LFSR tap table for the pattern generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int LFSR_MAX_W = 16;

  // Maximal-length feedback taps; bit n-1 set means stage n feeds the XOR.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;  // 4,3
      5:       return 16'h0014;  // 5,3
      6:       return 16'h0030;  // 6,5
      7:       return 16'h0060;  // 7,6
      8:       return 16'h00B8;  // 8,6,5,4
      9:       return 16'h0110;  // 9,5
      10:      return 16'h0240;  // 10,7
      11:      return 16'h0500;  // 11,9
      12:      return 16'h0829;  // 12,6,4,1
      13:      return 16'h100D;  // 13,4,3,1
      14:      return 16'h2015;  // 14,5,3,1
      15:      return 16'h6000;  // 15,14
      16:      return 16'hD008;  // 16,15,13,4
      default: return 16'h0000;
    endcase
  endfunction

  // One Fibonacci shift: XOR of the tapped stages enters at bit 0.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] v,
                                                      input int width);
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = 16'((32'd1 << width) - 32'd1);
    fb   = ^(v & lfsr_taps(width));
    return ((v << 1) | {15'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// WIDTH-bit Fibonacci LFSR with synchronous seed load and step enable.
module pattern_lfsr
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  // Load has priority over advance so a restart always begins at the seed.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= seed;
    end else if (advance) begin
      value_q <= WIDTH'(lfsr_next(16'(value_q), WIDTH));
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel test-pattern source with burst control and valid/ready output.
// WIDTH is expected to lie in 4..16 (LFSR tap table coverage).
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int CHANNELS  = 2,
  parameter int CH_OFFSET = 1,
  parameter int BURST_W   = 16
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          start_val,
  input  logic [WIDTH-1:0]          step,
  input  logic [BURST_W-1:0]        burst_len,
  input  logic                      start,
  input  logic                      stop,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam logic [WIDTH:0] MAX_V = {1'b0, {WIDTH{1'b1}}};

  state_t                    state_q;
  mode_t                     mode_q;
  dir_t                      dir_q, dir_d;
  logic [WIDTH-1:0]          step_q;
  logic [WIDTH-1:0]          v_q, v_d;
  logic [BURST_W-1:0]        burst_q, count_q;
  logic [CHANNELS*WIDTH-1:0] out_data_q;
  logic                      out_valid_q, busy_q, done_q;

  mode_t            mode_in;
  logic [WIDTH-1:0] seed, first_base, lfsr_value;
  logic [WIDTH:0]   tri_sum;
  logic             accept, handshake, last_sample;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (WIDTH - n));
  endfunction

  // Spread one base value across all channels: offset copies, or rotations for PRBS.
  function automatic logic [CHANNELS*WIDTH-1:0] fan_out(input logic [WIDTH-1:0] v,
                                                         input logic rotate);
    logic [CHANNELS*WIDTH-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rotate) r[c*WIDTH +: WIDTH] = rotl(v, c % WIDTH);
      else        r[c*WIDTH +: WIDTH] = v + WIDTH'(c * CH_OFFSET);
    end
    return r;
  endfunction

  assign mode_in     = mode_t'(mode);
  // A zero seed would lock the LFSR, so PRBS substitutes 1.
  assign seed        = (start_val == '0) ? WIDTH'(1) : start_val;
  assign first_base  = (mode_in == MODE_PRBS) ? seed : start_val;
  assign accept      = (state_q == ST_IDLE) && start;
  assign handshake   = (state_q == ST_RUN) && out_valid_q && out_ready;
  assign last_sample = handshake && (burst_q != '0) && (count_q == burst_q - BURST_W'(1));

  pattern_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (accept),
    .seed    (seed),
    .advance (handshake && (mode_q == MODE_PRBS)),
    .value   (lfsr_value)
  );

  // Next base value and triangle direction for the current mode.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    v_d     = v_q;
    dir_d   = dir_q;
    tri_sum = {1'b0, v_q} + {1'b0, step_q};
    case (mode_q)
      MODE_COUNT: v_d = v_q + step_q;
      MODE_TRI: begin
        if (dir_q == DIR_UP) begin
          if (tri_sum > MAX_V) begin
            v_d   = '1;
            dir_d = DIR_DOWN;
          end else begin
            v_d = tri_sum[WIDTH-1:0];
          end
        end else begin
          if (v_q < step_q) begin
            v_d   = '0;
            dir_d = DIR_UP;
          end else begin
            v_d = v_q - step_q;
          end
        end
      end
      MODE_PRBS:  v_d = WIDTH'(lfsr_next(16'(lfsr_value), WIDTH));
      default:    v_d = v_q;
    endcase
  end

  // Control FSM with registered stream outputs; data only moves on a handshake.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COUNT;
      dir_q       <= DIR_UP;
      step_q      <= '0;
      v_q         <= '0;
      burst_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            mode_q      <= mode_in;
            step_q      <= step;
            burst_q     <= burst_len;
            v_q         <= start_val;
            dir_q       <= DIR_UP;
            count_q     <= '0;
            out_data_q  <= fan_out(first_base, mode_in == MODE_PRBS);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (handshake) begin
            v_q        <= v_d;
            dir_q      <= dir_d;
            count_q    <= count_q + BURST_W'(1);
            out_data_q <= fan_out(v_d, mode_q == MODE_PRBS);
          end
          // Final sample and stop may coincide; either way one done pulse.
          if (last_sample || stop) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed, table-driven bench for pattern_gen (WIDTH=10 main, WIDTH=4 PRBS).
module tb_pattern_gen;

  localparam int W  = 10;
  localparam int CH = 2;
  localparam int BW = 16;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic [1:0]      mode = '0;
  logic [W-1:0]    start_val = '0, step = '0;
  logic [BW-1:0]   burst_len = '0;
  logic            start = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic [CH*W-1:0] out_data;
  logic            out_valid, busy, done;

  logic [1:0]      p_mode = 2'd2;
  logic [3:0]      p_start_val = '0, p_step = '0;
  logic [BW-1:0]   p_burst_len = '0;
  logic            p_start = 1'b0, p_stop = 1'b0, p_ready = 1'b0;
  logic [CH*4-1:0] p_data;
  logic            p_valid, p_busy, p_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_gen #(.WIDTH(W), .CHANNELS(CH), .CH_OFFSET(1), .BURST_W(BW)) u_dut (
    .clk(clk), .n_reset(n_reset), .mode(mode), .start_val(start_val), .step(step),
    .burst_len(burst_len), .start(start), .stop(stop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  pattern_gen #(.WIDTH(4), .CHANNELS(CH), .CH_OFFSET(1), .BURST_W(BW)) u_dut4 (
    .clk(clk), .n_reset(n_reset), .mode(p_mode), .start_val(p_start_val), .step(p_step),
    .burst_len(p_burst_len), .start(p_start), .stop(p_stop), .out_data(p_data),
    .out_valid(p_valid), .out_ready(p_ready), .busy(p_busy), .done(p_done)
  );

  typedef struct {
    logic         ready;
    logic         stop;
    logic         start;
    logic         chk_data;
    logic [W-1:0] ch0;
    logic [W-1:0] ch1;
    logic         valid;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rdy, input logic stp, input logic sta,
                              input logic cd, input logic [W-1:0] c0, input logic [W-1:0] c1,
                              input logic v, input logic b, input logic d);
    vec_t r;
    r.ready = rdy; r.stop = stp; r.start = sta; r.chk_data = cd;
    r.ch0 = c0; r.ch1 = c1; r.valid = v; r.busy = b; r.done = d;
    return r;
  endfunction

  // Start a burst, then scramble the config inputs to show they were latched.
  task automatic do_start(input logic [1:0] m, input logic [W-1:0] sv,
                          input logic [W-1:0] st, input logic [BW-1:0] bl);
    mode = m; start_val = sv; step = st; burst_len = bl; start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'd3; start_val = 10'h2AA; step = 10'h155; burst_len = 16'd1;
  endtask

  // Each vector: drive ready/stop/start, compare current outputs, advance one clock.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      out_ready = vecs[i].ready;
      stop      = vecs[i].stop;
      start     = vecs[i].start;
      if (vecs[i].chk_data) begin
        check($sformatf("%s[%0d].ch0", tag, i), 32'(out_data[W-1:0]), 32'(vecs[i].ch0));
        check($sformatf("%s[%0d].ch1", tag, i), 32'(out_data[2*W-1:W]), 32'(vecs[i].ch1));
      end
      check($sformatf("%s[%0d].valid", tag, i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vecs[i].done));
      tick();
    end
    out_ready = 1'b0; stop = 1'b0; start = 1'b0;
    vecs.delete();
  endtask

  logic [3:0] prbs_exp [15];

  initial begin
    prbs_exp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // Reset state
    tick(); tick();
    check("rst.data", 32'(out_data), 32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    n_reset = 1'b1;
    tick();

    // COUNT continuous across the wrap; a start mid-run is ignored; stop while held.
    do_start(2'd0, 10'h3FE, 10'h001, 16'd0);
    vecs.push_back(mk(1, 0, 0, 1, 10'h3FE, 10'h3FF, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3FF, 10'h000, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 10'h000, 10'h001, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h001, 10'h002, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 10'h002, 10'h003, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    run_vecs("count");

    // TRI burst of 6 reflecting at the top
    do_start(2'd1, 10'h3F0, 10'h008, 16'd6);
    vecs.push_back(mk(1, 0, 0, 1, 10'h3F0, 10'h3F1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3F8, 10'h3F9, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3FF, 10'h000, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3F7, 10'h3F8, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3EF, 10'h3F0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h3E7, 10'h3E8, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    run_vecs("tri");

    // Backpressure: ready 1,0,0,1 holds data and delivers 0,3,6 without skips
    do_start(2'd0, 10'h000, 10'h003, 16'd0);
    vecs.push_back(mk(1, 0, 0, 1, 10'h000, 10'h001, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 10'h003, 10'h004, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 10'h003, 10'h004, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h003, 10'h004, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h006, 10'h007, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 10'h009, 10'h00A, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    run_vecs("bp");

    // Stop coincident with the 5th handshake of a 10-sample burst
    do_start(2'd0, 10'h100, 10'h001, 16'd10);
    vecs.push_back(mk(1, 0, 0, 1, 10'h100, 10'h101, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h101, 10'h102, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h102, 10'h103, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h103, 10'h104, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 10'h104, 10'h105, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    run_vecs("stop5");

    // Stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop.busy", 32'(busy), 32'h0);
    check("idle_stop.done", 32'(done), 32'h0);

    // Restart from start_val; stop coincides with the final handshake -> one done
    do_start(2'd0, 10'h100, 10'h001, 16'd3);
    vecs.push_back(mk(1, 0, 0, 1, 10'h100, 10'h101, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h101, 10'h102, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 10'h102, 10'h103, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0));
    run_vecs("last_stop");

    // CONST holds start_val across handshakes
    do_start(2'd3, 10'h155, 10'h004, 16'd2);
    vecs.push_back(mk(1, 0, 0, 1, 10'h155, 10'h156, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 10'h155, 10'h156, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 1));
    run_vecs("const");

    // Reset asserted mid-burst drops outputs immediately, no done afterwards
    do_start(2'd0, 10'h000, 10'h001, 16'd0);
    out_ready = 1'b1;
    tick(); tick();
    n_reset = 1'b0;
    #2;
    check("midrst.valid", 32'(out_valid), 32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    check("midrst.done", 32'(done), 32'h0);
    check("midrst.data", 32'(out_data), 32'h0);
    tick();
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst[%0d].valid", i), 32'(out_valid), 32'h0);
      check($sformatf("postrst[%0d].busy", i), 32'(busy), 32'h0);
      check($sformatf("postrst[%0d].done", i), 32'(done), 32'h0);
    end
    out_ready = 1'b0;

    // PRBS at WIDTH=4, seed 0 -> 1: period 15, never zero, ch1 = rotl(ch0,1)
    p_mode = 2'd2; p_start_val = 4'h0; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    p_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e;
      e = prbs_exp[i % 15];
      check($sformatf("prbs[%0d].ch0", i), 32'(p_data[3:0]), 32'(e));
      check($sformatf("prbs[%0d].ch1", i), 32'(p_data[7:4]), 32'({e[2:0], e[3]}));
      check($sformatf("prbs[%0d].valid", i), 32'(p_valid), 32'h1);
      tick();
    end
    p_ready = 1'b0;
    p_stop = 1'b1;
    tick();
    p_stop = 1'b0;
    check("prbs_stop.done", 32'(p_done), 32'h1);
    check("prbs_stop.busy", 32'(p_busy), 32'h0);
    tick();
    check("prbs_stop.done_once", 32'(p_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
